// File: rtl/exception_sequencer_pkg.sv
// Shared codes for the exception sequencer: bank control codes, PC-source selects, FSM states.
package exception_sequencer_pkg;

  localparam logic [2:0] CTL_NOP     = 3'd0;
  localparam logic [2:0] CTL_WR_RES  = 3'd1;
  localparam logic [2:0] CTL_INIT    = 3'd2;
  localparam logic [2:0] CTL_WR_MEM  = 3'd3;
  localparam logic [2:0] CTL_SAVE_LR = 3'd4;

  localparam logic [1:0] PCS_DP  = 2'd0;
  localparam logic [1:0] PCS_VEC = 2'd1;
  localparam logic [1:0] PCS_LR  = 2'd2;

  typedef enum logic [2:0] {
    ST_INIT_U = 3'd0,
    ST_INIT_P = 3'd1,
    ST_RUN_U  = 3'd2,
    ST_ENTER  = 3'd3,
    ST_RUN_P  = 3'd4,
    ST_EXIT   = 3'd5
  } state_t;

endpackage

// File: rtl/exception_sequencer_irq_prio_enc.sv
// Fixed-priority encoder: lowest set line wins; idx is line number + 1 (0 when nothing pending).
module irq_prio_enc #(
  parameter int N_IRQ = 4
) (
  input  logic [N_IRQ-1:0] irq,
  output logic             valid,
  output logic [3:0]       idx
);

  always_comb begin
    valid = 1'b0;
    idx   = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) begin
        valid = 1'b1;
        idx   = 4'(i + 1);
      end
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Sequences bank control/mode/PC-source for reset SP init, exception entry (SWI/IRQ) and return.
// Outputs are decoded from the registered state plus the decoder inputs in the run states.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int          N_IRQ    = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0010
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_boundary,
  input  logic [2:0]       dec_control,
  input  logic             dec_enable,
  input  logic             swi,
  input  logic             rfe,
  input  logic [N_IRQ-1:0] irq,
  output logic [2:0]       control,
  output logic             enable,
  output logic             M,
  output logic [1:0]       pc_sel,
  output logic [31:0]      vector,
  output logic             stall,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [3:0]       cause
);

  state_t     state_q, state_d;
  logic       swi_pend_q, swi_pend_d;
  logic [3:0] cause_q, cause_d;

  logic       irq_vld;
  logic [3:0] irq_idx;
  logic [2:0] dec_ctl_fwd;

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .irq   (irq),
    .valid (irq_vld),
    .idx   (irq_idx)
  );

  always_comb begin
    state_d    = state_q;
    swi_pend_d = swi_pend_q;
    cause_d    = cause_q;
    case (state_q)
      ST_INIT_U: state_d = ST_INIT_P;
      ST_INIT_P: state_d = ST_RUN_U;
      ST_RUN_U: begin
        swi_pend_d = swi_pend_q | swi;
        if (instr_boundary && (swi_pend_d || irq_vld)) begin
          state_d = ST_ENTER;
          cause_d = swi_pend_d ? 4'd0 : irq_idx;
        end
      end
      ST_ENTER: begin
        state_d = ST_RUN_P;
        if (cause_q == 4'd0) swi_pend_d = 1'b0;
      end
      // IRQs masked and SWI dropped while privileged; only rfe leaves.
      ST_RUN_P: if (rfe) state_d = ST_EXIT;
      ST_EXIT:  state_d = ST_RUN_U;
      default:  state_d = ST_INIT_U;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT_U;
      swi_pend_q <= 1'b0;
      cause_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      swi_pend_q <= swi_pend_d;
      cause_q    <= cause_d;
    end
  end

  // Code 4 belongs to this block; a decoder request for it degrades to NOP.
  assign dec_ctl_fwd = (dec_control == CTL_SAVE_LR) ? CTL_NOP : dec_control;

  always_comb begin
    control = CTL_INIT;
    enable  = 1'b1;
    M       = 1'b0;
    pc_sel  = PCS_DP;
    stall   = 1'b1;
    irq_ack = '0;
    case (state_q)
      ST_INIT_P: M = 1'b1;
      ST_RUN_U: begin
        control = dec_ctl_fwd;
        enable  = dec_enable;
        stall   = 1'b0;
      end
      ST_RUN_P: begin
        control = dec_ctl_fwd;
        enable  = dec_enable;
        M       = 1'b1;
        stall   = 1'b0;
      end
      ST_ENTER: begin
        control = CTL_SAVE_LR;
        pc_sel  = PCS_VEC;
        for (int i = 0; i < N_IRQ; i++) irq_ack[i] = (cause_q == 4'(i + 1));
      end
      ST_EXIT: begin
        control = CTL_NOP;
        pc_sel  = PCS_LR;
        M       = 1'b1;
      end
      default: ;
    endcase
  end

  assign vector = VEC_BASE + 32'(cause_q);
  assign cause  = cause_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: behavioural model checked every cycle plus literal spot checks.
module tb_exception_sequencer;

  localparam int          N_IRQ    = 4;
  localparam logic [31:0] VEC_BASE = 32'h0000_0010;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             instr_boundary = 1'b0;
  logic [2:0]       dec_control = 3'd0;
  logic             dec_enable = 1'b0;
  logic             swi = 1'b0;
  logic             rfe = 1'b0;
  logic [N_IRQ-1:0] irq = '0;
  logic [2:0]       control;
  logic             enable;
  logic             M;
  logic [1:0]       pc_sel;
  logic [31:0]      vector;
  logic             stall;
  logic [N_IRQ-1:0] irq_ack;
  logic [3:0]       cause;

  int tests = 0;
  int fails = 0;

  exception_sequencer #(.N_IRQ(N_IRQ), .VEC_BASE(VEC_BASE)) dut (
    .clock          (clock),
    .reset          (reset),
    .instr_boundary (instr_boundary),
    .dec_control    (dec_control),
    .dec_enable     (dec_enable),
    .swi            (swi),
    .rfe            (rfe),
    .irq            (irq),
    .control        (control),
    .enable         (enable),
    .M              (M),
    .pc_sel         (pc_sel),
    .vector         (vector),
    .stall          (stall),
    .irq_ack        (irq_ack),
    .cause          (cause)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: init cycles still to run, plus flags for the one-cycle entry/exit steps.
  int   m_init_left = 2;
  bit   m_priv = 0, m_entering = 0, m_leaving = 0, m_pend = 0;
  int   m_cause = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_init_left = 2; m_priv = 0; m_entering = 0; m_leaving = 0; m_pend = 0; m_cause = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (m_entering) begin
      m_entering = 0;
      m_priv     = 1;
      if (m_cause == 0) m_pend = 0;
    end else if (m_leaving) begin
      m_leaving = 0;
      m_priv    = 0;
    end else if (m_priv) begin
      if (rfe) m_leaving = 1;
    end else begin
      int first;
      first = 0;
      for (int i = N_IRQ - 1; i >= 0; i--) if (irq[i]) first = i + 1;
      m_pend = m_pend || swi;
      if (instr_boundary && (m_pend || first != 0)) begin
        m_entering = 1;
        m_cause    = m_pend ? 0 : first;
      end
    end
  end

  always @(negedge clock) begin
    logic [2:0] e_ctl;
    logic       e_en, e_m, e_stall;
    logic [1:0] e_pcs;
    logic [3:0] e_ack;
    e_ack = 4'b0;
    if (m_init_left == 2) begin
      e_ctl = 3'd2; e_en = 1; e_m = 0; e_pcs = 2'd0; e_stall = 1;
    end else if (m_init_left == 1) begin
      e_ctl = 3'd2; e_en = 1; e_m = 1; e_pcs = 2'd0; e_stall = 1;
    end else if (m_entering) begin
      e_ctl = 3'd4; e_en = 1; e_m = 0; e_pcs = 2'd1; e_stall = 1;
      if (m_cause != 0) e_ack = 4'(1 << (m_cause - 1));
    end else if (m_leaving) begin
      e_ctl = 3'd0; e_en = 1; e_m = 1; e_pcs = 2'd2; e_stall = 1;
    end else begin
      e_ctl = (dec_control == 3'd4) ? 3'd0 : dec_control;
      e_en = dec_enable; e_m = m_priv; e_pcs = 2'd0; e_stall = 0;
    end
    chk("model_control", 32'(control), 32'(e_ctl));
    chk("model_enable",  32'(enable),  32'(e_en));
    chk("model_M",       32'(M),       32'(e_m));
    chk("model_pc_sel",  32'(pc_sel),  32'(e_pcs));
    chk("model_stall",   32'(stall),   32'(e_stall));
    chk("model_irq_ack", 32'(irq_ack), 32'(e_ack));
    chk("model_cause",   32'(cause),   32'(m_cause));
    chk("model_vector",  vector,       VEC_BASE + 32'(m_cause));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    tick(2);
    chk("rst_control", 32'(control), 32'd2);
    chk("rst_M", 32'(M), 32'd0);
    chk("rst_vector", vector, 32'h10);
    reset = 1'b0;
    #1;
    chk("init_u_ctl", 32'(control), 32'd2);
    chk("init_u_M", 32'(M), 32'd0);
    tick();
    chk("init_p_ctl", 32'(control), 32'd2);
    chk("init_p_M", 32'(M), 32'd1);
    chk("init_p_stall", 32'(stall), 32'd1);
    tick();
    chk("run_u_stall", 32'(stall), 32'd0);

    // passthrough and forcing of code 4
    dec_control = 3'd3; dec_enable = 1'b1; #1;
    chk("pass_ctl3", 32'(control), 32'd3);
    dec_control = 3'd4; #1;
    chk("force4", 32'(control), 32'd0);
    tick();
    dec_control = 3'd1; dec_enable = 1'b0;

    // SWI two cycles ahead of the boundary
    swi = 1'b1; tick(); swi = 1'b0; tick();
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("swi_ctl", 32'(control), 32'd4);
    chk("swi_pcsel", 32'(pc_sel), 32'd1);
    chk("swi_vec", vector, 32'h10);
    chk("swi_cause", 32'(cause), 32'd0);
    tick();
    chk("swi_runp_M", 32'(M), 32'd1);
    swi = 1'b1; dec_control = 3'd2; tick(); swi = 1'b0;
    rfe = 1'b1; tick(); rfe = 1'b0;
    chk("exit_pcsel", 32'(pc_sel), 32'd2);
    chk("exit_ctl", 32'(control), 32'd0);
    chk("exit_M", 32'(M), 32'd1);
    tick();
    chk("ret_M", 32'(M), 32'd0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("swi_runp_dropped", 32'(stall), 32'd0);

    // IRQ 0110: line 1 wins, line 2 left pending
    irq = 4'b0110; instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("irq_cause", 32'(cause), 32'd2);
    chk("irq_vec", vector, 32'h12);
    chk("irq_ack", 32'(irq_ack), 32'b0010);
    irq = 4'b0100; tick();
    chk("irq_ack_once", 32'(irq_ack), 32'd0);
    instr_boundary = 1'b1; tick(2); instr_boundary = 1'b0;
    chk("irq_masked", 32'(stall), 32'd0);
    rfe = 1'b1; tick(); rfe = 1'b0; tick();
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("irq2_cause", 32'(cause), 32'd3);
    chk("irq2_ack", 32'(irq_ack), 32'b0100);
    irq = 4'b0000; tick();
    rfe = 1'b1; tick(); rfe = 1'b0; tick();

    // SWI and irq[0] together
    irq = 4'b0001; swi = 1'b1; instr_boundary = 1'b1; tick();
    swi = 1'b0; instr_boundary = 1'b0;
    chk("both_cause", 32'(cause), 32'd0);
    tick(2);
    rfe = 1'b1; tick(); rfe = 1'b0; tick();
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("irq0_vec", vector, 32'h11);
    irq = 4'b0000; tick();
    rfe = 1'b1; swi = 1'b1; tick(); rfe = 1'b0; swi = 1'b0;
    chk("rfe_wins", 32'(pc_sel), 32'd2);
    tick();
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("rfe_swi_dropped", 32'(stall), 32'd0);

    // reset in the middle of ENTER
    irq = 4'b0001; instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    #2 reset = 1'b1; #1;
    chk("rst_enter_M", 32'(M), 32'd0);
    chk("rst_enter_ctl", 32'(control), 32'd2);
    chk("rst_enter_ack", 32'(irq_ack), 32'd0);
    chk("rst_enter_cause", 32'(cause), 32'd0);
    irq = 4'b0000;
    tick(); reset = 1'b0; tick(2);

    // pending SWI cleared by reset
    swi = 1'b1; tick(); swi = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick(2);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    chk("pend_cleared", 32'(stall), 32'd0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
